// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
//
// Sequencer/arbiter behind the multi-key debouncer. Watches the debounced key
// levels and detects each key release. It classifies a release as a long press
// when the key was held for at least LONG_CNT cycles, otherwise as a short press.
// It holds at most one pending event per key. Events are issued one at a time to
// the downstream consumer. When several events are pending, the lowest key index
// is served first.
//
// Handshake: evt_valid/evt_id/evt_long form a registered valid/ready source.
// An event transfers on a rising edge where evt_valid & evt_ready are both high.
// Once evt_valid is raised, evt_id and evt_long hold steady until that transfer.
// The consumer may raise evt_ready at any time. evt_ready is ignored while
// evt_valid is low.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   key_down   debounced key levels, 1 = pressed
//   evt_valid  event presented on evt_id / evt_long
//   evt_ready  consumer accepts the presented event
//   evt_id     index of the key that generated the event
//   evt_long   1 = long press, 0 = short press
//   evt_drop   one-cycle pulse per key: a release was lost because that key
//              already had an event pending
// -----------------------------------------------------------------------------
module key_event_ctrl #(
    parameter  int KEY_W    = 3,
    parameter  int LONG_CNT = 100,
    localparam int CNT_W    = $clog2(LONG_CNT + 1),
    localparam int ID_W     = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_down,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_long,
    output logic [KEY_W-1:0] evt_drop
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t state;

    logic [KEY_W-1:0] key_d;
    logic [KEY_W-1:0] pending;
    logic [KEY_W-1:0] pend_long;
    logic [CNT_W-1:0] hold_cnt [KEY_W];

    logic [KEY_W-1:0] release_v;
    logic [KEY_W-1:0] long_v;
    logic [KEY_W-1:0] pick_oh;
    logic [ID_W-1:0]  pick_id;
    logic             any_pend;
    logic             take;
    logic [KEY_W-1:0] grant_oh;
    logic [KEY_W-1:0] store_v;
    logic [KEY_W-1:0] drop_v;

    // A release is the falling edge of the debounced level.
    assign release_v = key_d & ~key_down;

    // The counter saturates at LONG_CNT, so "long" means held at least LONG_CNT cycles.
    always_comb begin
        long_v = '0;
        for (int i = 0; i < KEY_W; i++) begin
            long_v[i] = (hold_cnt[i] == CNT_W'(LONG_CNT));
        end
    end

    // Fixed priority: the lowest set bit of pending wins.
    assign pick_oh  = pending & (~pending + KEY_W'(1));
    assign any_pend = |pending;

    always_comb begin
        pick_id = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_id = ID_W'(i);
            end
        end
    end

    // A pending event is granted when the output slot is empty (IDLE) or is being
    // emptied this edge (PRESENT with ready). Back-to-back grants keep one
    // event per cycle flowing.
    assign take     = any_pend && ((state == IDLE) || evt_ready);
    assign grant_oh = take ? pick_oh : '0;

    // If a key is released on the same edge that its pending entry is granted,
    // the pending slot frees up. The new release is then stored, not dropped.
    assign store_v = release_v & (~pending | grant_oh);
    assign drop_v  = release_v & pending & ~grant_oh;

    // Hold counters: count while pressed, saturate, clear when released.
    always_ff @(posedge clk) begin
        for (int i = 0; i < KEY_W; i++) begin
            if (rst || !key_down[i]) begin
                hold_cnt[i] <= '0;
            end else if (hold_cnt[i] != CNT_W'(LONG_CNT)) begin
                hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Edge detect, pending bookkeeping and the output FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_d     <= '0;
            pending   <= '0;
            pend_long <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_long  <= 1'b0;
            evt_drop  <= '0;
        end else begin
            key_d     <= key_down;
            evt_drop  <= drop_v;
            pending   <= (pending & ~grant_oh) | store_v;
            pend_long <= (pend_long & ~store_v) | (long_v & store_v);

            case (state)
                IDLE: begin
                    if (any_pend) begin
                        state     <= PRESENT;
                        evt_valid <= 1'b1;
                        evt_id    <= pick_id;
                        evt_long  <= |(pend_long & pick_oh);
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        if (any_pend) begin
                            evt_id   <= pick_id;
                            evt_long <= |(pend_long & pick_oh);
                        end else begin
                            state     <= IDLE;
                            evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
